// File: rtl/mult_requester_pkg.sv
// Shared types for the multiplier requester: FSM state encoding and default operand width.
package mult_requester_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_req_counter.sv
// Loadable up-counter with synchronous clear and terminal-count compare; clear beats load beats increment.
module mult_req_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/mult_requester.sv
// Hands one operand pair at a time to a multiplier controller and holds the result until taken downstream.
// Optional WAIT timeout (out_err=1, out_res=0) is compiled in with MULT_REQ_TIMEOUT_EN.
module mult_requester
  import mult_requester_pkg::*;
#(
  parameter int N            = N_DEFAULT,
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           mul_start,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic           mul_done,
  input  logic [2*N-1:0] mul_res,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_res,
  output logic           out_err,
  output logic           busy
);

  if (START_CYCLES < 1 || START_CYCLES > 15 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mult_requester: START_CYCLES must be 1..15 and TIMEOUT at least 1");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
  logic [2*N-1:0] out_res_q, out_res_d;
  logic           mul_start_q, mul_start_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           in_ready_q, in_ready_d;

  logic st_clr, st_inc, st_tc;

  mult_req_counter #(.W(4)) u_start_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (st_clr),
    .ld     (1'b0),
    .ld_val (4'd0),
    .inc    (st_inc),
    .term   (4'(START_CYCLES - 1)),
    .tc     (st_tc)
  );

`ifdef MULT_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic out_err_q, out_err_d;
  logic to_clr, to_inc, to_tc;

  mult_req_counter #(.W(TW)) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (to_clr),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (to_inc),
    .term   (TW'(TIMEOUT - 1)),
    .tc     (to_tc)
  );

  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    out_res_d = out_res_q;
    st_clr    = 1'b0;
    st_inc    = 1'b0;
`ifdef MULT_REQ_TIMEOUT_EN
    out_err_d = out_err_q;
    to_clr    = 1'b0;
    to_inc    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          st_clr  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (st_tc) begin
          state_d = WAIT;
`ifdef MULT_REQ_TIMEOUT_EN
          to_clr  = 1'b1;
`endif
        end else begin
          st_inc = 1'b1;
        end
      end
      WAIT: begin
        // a completion in the timeout cycle still wins and reports success
        if (mul_done) begin
          out_res_d = mul_res;
`ifdef MULT_REQ_TIMEOUT_EN
          out_err_d = 1'b0;
`endif
          state_d   = HOLD;
`ifdef MULT_REQ_TIMEOUT_EN
        end else if (to_tc) begin
          out_res_d = '0;
          out_err_d = 1'b1;
          state_d   = HOLD;
        end else begin
          to_inc = 1'b1;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // outputs are decoded from the next state so they leave the flops aligned with it
    mul_start_d = (state_d == START);
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_res_q   <= '0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef MULT_REQ_TIMEOUT_EN
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_res_q   <= out_res_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
`ifdef MULT_REQ_TIMEOUT_EN
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign busy      = busy_q;

endmodule
